uart_frame_parser: RTL and testbench



---
 rtl/uart_frame_parser_if.sv | 29 ++
 rtl/uart_frame_parser.sv | 191 +++++++++++++++++++
 tb/tb_uart_frame_parser.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_parser_if.sv
// uart_frame_parser_if
//   Groups the parser's byte-input, payload-output and status signals.
//   master : byte source / payload consumer / status observer
//   slave  : the frame parser itself
//   data, data_valid : received byte and its one-cycle strobe
//   out_data, out_valid, out_ready, out_last : payload stream with handshake
//   frame_ok, frame_err, err_code, dropped : status pulses and error cause
interface uart_frame_parser_if;
  logic [7:0] data;
  logic       data_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       dropped;

  modport master (
    output data, data_valid, out_ready,
    input  out_data, out_valid, out_last, frame_ok, frame_err, err_code, dropped
  );

  modport slave (
    input  data, data_valid, out_ready,
    output out_data, out_valid, out_last, frame_ok, frame_err, err_code, dropped
  );
endinterface

// File: rtl/uart_frame_parser.sv
// uart_frame_parser
//   Parses SYNC, LEN, payload[LEN], CHK frames from a byte stream, where
//   CHK is the XOR of LEN and every payload byte. Good payloads are replayed
//   on a valid/ready stream with a last marker; bad frames raise frame_err
//   with a cause code (1 checksum, 2 length, 3 inter-byte timeout).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : slave side of uart_frame_parser_if (bytes in, payload/status out)
module uart_frame_parser #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int          MAX_LEN        = 16,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input logic               clk,
  input logic               reset,
  uart_frame_parser_if.slave bus
);

  localparam int IW = $clog2(MAX_LEN + 1);            // index holds MAX_LEN
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LEN     = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_CHK     = 3'd3;
  localparam logic [2:0] S_EMIT    = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    xor_q, xor_d;
  logic [IW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic          ok_q, ok_d, err_q, err_d, drop_q, drop_d;
  logic [1:0]    code_q, code_d;
  logic          mem_we;
  logic [7:0]    mem_q [0:MAX_LEN-1];
  logic [IW-1:0] nxt_wr, nxt_rd;

  assign nxt_wr = wr_q + 1'b1;
  assign nxt_rd = rd_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    xor_d       = xor_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    ok_d        = 1'b0;
    err_d       = 1'b0;
    drop_d      = 1'b0;
    code_d      = code_q;
    mem_we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.data_valid && bus.data == SYNC_BYTE) begin
          state_d = S_LEN;
          cnt_d   = '0;
        end
      end

      S_LEN, S_PAYLOAD, S_CHK: begin
        // An arriving byte takes priority over a simultaneous timeout.
        if (bus.data_valid) begin
          cnt_d = '0;
          case (state_q)
            S_LEN: begin
              len_d = bus.data;
              xor_d = bus.data;
              wr_d  = '0;
              if (bus.data > MAX_LEN_B) begin
                err_d   = 1'b1;
                code_d  = 2'd2;
                state_d = S_IDLE;
              end else if (bus.data == 8'd0) begin
                state_d = S_CHK;
              end else begin
                state_d = S_PAYLOAD;
              end
            end
            S_PAYLOAD: begin
              mem_we = 1'b1;
              xor_d  = xor_q ^ bus.data;
              wr_d   = nxt_wr;
              if (8'(nxt_wr) == len_q) state_d = S_CHK;
            end
            default: begin  // S_CHK
              if (bus.data == xor_q) begin
                ok_d = 1'b1;
                if (len_q != 8'd0) begin
                  // Present the first byte alongside frame_ok.
                  state_d     = S_EMIT;
                  rd_d        = '0;
                  out_valid_d = 1'b1;
                  out_data_d  = mem_q[0];
                  out_last_d  = (len_q == 8'd1);
                end else begin
                  state_d = S_IDLE;
                end
              end else begin
                err_d   = 1'b1;
                code_d  = 2'd1;
                state_d = S_IDLE;
              end
            end
          endcase
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          code_d  = 2'd3;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_EMIT: begin
        drop_d = bus.data_valid;
        if (out_valid_q && bus.out_ready) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = S_IDLE;
          end else begin
            rd_d       = nxt_rd;
            out_data_d = mem_q[nxt_rd[AW-1:0]];
            out_last_d = (8'(nxt_rd) == len_q - 8'd1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      xor_q       <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
      drop_q      <= 1'b0;
      code_q      <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      xor_q       <= xor_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
      drop_q      <= drop_d;
      code_q      <= code_d;
    end
  end

  // Payload storage has no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_q[AW-1:0]] <= bus.data;
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.frame_ok  = ok_q;
  assign bus.frame_err = err_q;
  assign bus.err_code  = code_q;
  assign bus.dropped   = drop_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
module tb_uart_frame_parser;
  localparam int ML = 16;
  localparam int TO = 20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_frame_parser_if bus ();

  uart_frame_parser #(.SYNC_BYTE(8'hA5), .MAX_LEN(ML), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_pass = 0;
  int n_tot  = 0;
  int n_ok = 0, n_err = 0, n_drop = 0, n_both = 0;
  logic [8:0] rx_q[$];   // {last, data} of every accepted transfer

  // Observe the stream mid-cycle; inputs are driven 2 time units after posedge.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.out_valid && bus.out_ready) rx_q.push_back({bus.out_last, bus.out_data});
      if (bus.frame_ok) n_ok++;
      if (bus.frame_err) n_err++;
      if (bus.dropped) n_drop++;
      if (bus.frame_ok && bus.frame_err) n_both++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] b);
    bus.data       = b;
    bus.data_valid = 1'b1;
    tick();
    bus.data_valid = 1'b0;
  endtask

  function automatic logic [7:0] xor_of(input logic [7:0] len, input logic [7:0] pl[$]);
    logic [7:0] x = len;
    foreach (pl[i]) x ^= pl[i];
    return x;
  endfunction

  // Reference: 0 = good frame, else the err_code the frame must produce.
  function automatic int model_code(input logic [7:0] len, input logic [7:0] pl[$],
                                    input logic [7:0] c);
    if (len > ML) return 2;
    if (c != xor_of(len, pl)) return 1;
    return 0;
  endfunction

  task automatic do_frame(input logic [7:0] len, input logic [7:0] pl[$],
                          input logic [7:0] c, input string tag);
    int exp, ok0, err0, nexp;
    exp  = model_code(len, pl, c);
    ok0  = n_ok;
    err0 = n_err;
    rx_q.delete();
    bus.out_ready = 1'b1;
    send(8'hA5);
    send(len);
    if (len <= ML) begin
      foreach (pl[i]) send(pl[i]);
      send(c);
    end
    chk({tag, ".frame_ok"}, bus.frame_ok, exp == 0);
    chk({tag, ".frame_err"}, bus.frame_err, exp != 0);
    if (exp != 0) chk({tag, ".err_code"}, bus.err_code, exp);
    if (exp == 0 && len != 0) begin
      chk({tag, ".first_valid"}, bus.out_valid, 1);
      chk({tag, ".first_data"}, bus.out_data, pl[0]);
    end else begin
      chk({tag, ".no_valid"}, bus.out_valid, 0);
    end
    repeat (int'(len) + 3) tick();
    nexp = (exp == 0) ? int'(len) : 0;
    chk({tag, ".count"}, rx_q.size(), nexp);
    if (rx_q.size() == nexp) begin
      for (int i = 0; i < nexp; i++)
        chk({tag, ".byte"}, rx_q[i], {i == nexp - 1, pl[i]});
    end
    chk({tag, ".ok_pulses"}, n_ok - ok0, exp == 0);
    chk({tag, ".err_pulses"}, n_err - err0, exp != 0);
  endtask

  initial begin
    logic [7:0] pl[$];
    logic [7:0] len, c;
    int d0;

    reset = 1'b1;
    bus.data = 8'h00;
    bus.data_valid = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst.out_valid", bus.out_valid, 0);
    chk("rst.out_last", bus.out_last, 0);
    chk("rst.out_data", bus.out_data, 0);
    chk("rst.frame_ok", bus.frame_ok, 0);
    chk("rst.frame_err", bus.frame_err, 0);
    chk("rst.err_code", bus.err_code, 0);
    chk("rst.dropped", bus.dropped, 0);
    tick();
    reset = 1'b0;
    tick();

    // Good frame, then bad checksum, then recovery.
    pl = '{8'h11, 8'h22, 8'h33};
    do_frame(8'd3, pl, 8'h03, "good3");
    pl = '{8'h10, 8'h20};
    do_frame(8'd2, pl, 8'h00, "badchk");
    pl = '{8'h55};
    do_frame(8'd1, pl, 8'h54, "good1");

    // Junk ahead of SYNC, oversize length, zero length.
    send(8'h00); send(8'hFF); send(8'h3C);
    tick();
    chk("junk.no_err", n_err, 1);
    pl.delete();
    do_frame(8'h11, pl, 8'h00, "len17");
    do_frame(8'h00, pl, 8'h00, "len0");

    // Payload containing the sync value is ordinary data.
    pl = '{8'hA5, 8'hA5, 8'h01};
    do_frame(8'd3, pl, xor_of(8'd3, pl), "syncdata");

    // Maximum length boundary.
    pl.delete();
    for (int i = 0; i < ML; i++) pl.push_back(8'($urandom_range(0, 255)));
    do_frame(8'(ML), pl, xor_of(8'(ML), pl), "maxlen");

    // Backpressure and dropped byte during EMIT.
    rx_q.delete();
    bus.out_ready = 1'b0;
    d0 = n_drop;
    send(8'hA5); send(8'h02); send(8'hAA); send(8'hBB); send(8'h13);
    chk("bp.frame_ok", bus.frame_ok, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp.valid", bus.out_valid, 1);
      chk("bp.data", bus.out_data, 8'hAA);
      chk("bp.last", bus.out_last, 0);
      tick();
    end
    send(8'h77);
    chk("bp.dropped", bus.dropped, 1);
    chk("bp.data_after_drop", bus.out_data, 8'hAA);
    bus.out_ready = 1'b1;
    repeat (3) tick();
    chk("bp.count", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      chk("bp.byte0", rx_q[0], {1'b0, 8'hAA});
      chk("bp.byte1", rx_q[1], {1'b1, 8'hBB});
    end
    chk("bp.drop_pulses", n_drop - d0, 1);
    chk("bp.idle_valid", bus.out_valid, 0);

    // Timeout fires exactly TO edges after the last accepted byte.
    send(8'hA5); send(8'h04); send(8'h01);
    repeat (TO - 1) tick();
    chk("to.not_yet", bus.frame_err, 0);
    tick();
    chk("to.err", bus.frame_err, 1);
    chk("to.code", bus.err_code, 3);
    tick();

    // A byte landing on the limit cycle is accepted instead.
    d0 = n_err;
    send(8'hA5); send(8'h04); send(8'h01);
    repeat (TO - 1) tick();
    send(8'h02);
    chk("to.byte_wins", bus.frame_err, 0);
    send(8'h03); send(8'h04);
    send(8'h04 ^ 8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04);
    chk("to.late_frame_ok", bus.frame_ok, 1);
    repeat (8) tick();
    chk("to.no_err", n_err - d0, 0);
    chk("to.code_held", bus.err_code, 3);

    // Reset during EMIT clears output asynchronously.
    bus.out_ready = 1'b0;
    send(8'hA5); send(8'h01); send(8'h5A); send(8'h5B);
    chk("rstemit.valid_before", bus.out_valid, 1);
    #1 reset = 1'b1;
    #1;
    chk("rstemit.valid_async", bus.out_valid, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("rstemit.code_cleared", bus.err_code, 0);
    pl = '{8'h01, 8'h02, 8'h03};
    do_frame(8'd3, pl, xor_of(8'd3, pl), "after_rst");

    // Randomized frames against the reference model.
    for (int f = 0; f < 10; f++) begin
      len = 8'($urandom_range(0, ML));
      pl.delete();
      for (int i = 0; i < int'(len); i++) pl.push_back(8'($urandom_range(0, 255)));
      c = xor_of(len, pl);
      if ($urandom_range(0, 2) == 0) c ^= 8'($urandom_range(1, 255));
      do_frame(len, pl, c, "rand");
    end
    pl.delete();
    do_frame(8'($urandom_range(ML + 1, 255)), pl, 8'h00, "rand_oversize");

    chk("never_both", n_both, 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
